mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_select.sv | 31 +++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
//
// Purpose : state encoding, grant encoding and counter width used by
//           mem_arbiter and arb_select.
// Contents: CNT_W   - width of the BUSY-phase latency counter
//           state_t - IDLE / BUSY / RESP
//           grant_t - GNT_CPU (0) / GNT_EXT (1)
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_EXT = 1'b1
  } grant_t;

endpackage

// File: rtl/arb_select.sv
// rtl/arb_select.sv - combinational winner selection between core and external port
//
// Purpose : picks which requester is served next. A lone request always wins;
//           on a tie the requester that was not granted last wins.
// Ports   : cpu_req    in  core request
//           ext_req    in  external request
//           last_grant in  previous winner (tie-break history)
//           grant      out selected requester (GNT_CPU when nobody requests)
module arb_select
  import mem_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   ext_req,
  input  grant_t last_grant,
  output grant_t grant
);

  always_comb begin
    grant = GNT_CPU;
    if (cpu_req && ext_req) begin
      if (last_grant == GNT_CPU) begin
        grant = GNT_EXT;
      end else begin
        grant = GNT_CPU;
      end
    end else if (ext_req) begin
      grant = GNT_EXT;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of a single shared memory
//
// Purpose : serialises core and external (debug/DMA) accesses onto one memory
//           port. Each transaction runs IDLE -> BUSY (LATENCY cycles) -> RESP.
// Params  : DATA_W, ADDR_W, LATENCY (1..15 BUSY cycles per transaction)
// Macro   : MEM_ARB_ROUND_ROBIN_EN - when defined, ties alternate between the
//           two requesters; otherwise the core always wins a tie.
// Ports   : clk, reset (async, active high)
//           cpu_req/cpu_we/cpu_adr/cpu_wd in, cpu_rd/cpu_ready out
//           ext_req/ext_we/ext_adr/ext_wd in, ext_rd/ext_ready out
//           mem_en/mem_we/mem_adr/mem_wd out, mem_rd in
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              cpu_ready,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_adr,
  input  logic [DATA_W-1:0] ext_wd,
  output logic [DATA_W-1:0] ext_rd,
  output logic              ext_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  grant_t            gnt;
  grant_t            sel;
  grant_t            last_grant;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_adr;
  logic [DATA_W-1:0] lat_wd;
  logic              any_req;
  logic              start;
  logic              last_busy;

  assign any_req   = cpu_req | ext_req;
  assign start     = (state == IDLE) && any_req;
  // cnt counts down the remaining BUSY cycles; zero marks the final one.
  assign last_busy = (state == BUSY) && (cnt == '0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Reset to EXT so the first tie after reset goes to the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GNT_EXT;
    end else if (start) begin
      last_grant <= sel;
    end
  end
`else
  // Fixed history of EXT makes every tie resolve to the core.
  assign last_grant = GNT_EXT;
`endif

  arb_select u_arb_select (
    .cpu_req    (cpu_req),
    .ext_req    (ext_req),
    .last_grant (last_grant),
    .grant      (sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wd    = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        mem_en  = 1'b1;
        mem_we  = lat_we;
        mem_adr = lat_adr;
        mem_wd  = lat_wd;
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request fields are captured once at grant time so requesters may change
  // their inputs while the access is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      gnt       <= GNT_CPU;
      lat_we    <= 1'b0;
      lat_adr   <= '0;
      lat_wd    <= '0;
      cpu_rd    <= '0;
      ext_rd    <= '0;
      cpu_ready <= 1'b0;
      ext_ready <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      ext_ready <= 1'b0;
      if (start) begin
        gnt <= sel;
        cnt <= CNT_W'(LATENCY - 1);
        if (sel == GNT_CPU) begin
          lat_we  <= cpu_we;
          lat_adr <= cpu_adr;
          lat_wd  <= cpu_wd;
        end else begin
          lat_we  <= ext_we;
          lat_adr <= ext_adr;
          lat_wd  <= ext_wd;
        end
      end else if (last_busy) begin
        // Ready is registered here so it is high exactly during RESP.
        if (gnt == GNT_CPU) begin
          cpu_rd    <= mem_rd;
          cpu_ready <= 1'b1;
        end else begin
          ext_rd    <= mem_rd;
          ext_ready <= 1'b1;
        end
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at LATENCY 1 and 3
module tb_mem_arbiter;

  localparam int L0 = 1;
  localparam int L1 = 3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    int          d;
    bit          who;
    bit          we;
    logic [31:0] adr;
    logic [31:0] wd;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req [2];
  logic        cpu_we  [2];
  logic [31:0] cpu_adr [2];
  logic [31:0] cpu_wd  [2];
  logic [31:0] cpu_rd  [2];
  logic        cpu_ready [2];
  logic        ext_req [2];
  logic        ext_we  [2];
  logic [31:0] ext_adr [2];
  logic [31:0] ext_wd  [2];
  logic [31:0] ext_rd  [2];
  logic        ext_ready [2];
  logic        mem_en  [2];
  logic        mem_we  [2];
  logic [31:0] mem_adr [2];
  logic [31:0] mem_wd  [2];
  logic [31:0] mem_rd  [2];

  txn_t        sbq[$];
  int          busy_cnt [2];
  logic [31:0] exp_cpu_rd [2];
  logic [31:0] exp_ext_rd [2];
  bit          mlast;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    if (a == 32'h40) return 32'hDEADBEEF;
    return {lo ^ 16'h5A5A, lo};
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? L0 : L1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_mem
    assign mem_rd[g] = mem_en[g] ? mem_fn(mem_adr[g]) : 32'h0;
  end

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .LATENCY(L0)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_adr(cpu_adr[0]), .cpu_wd(cpu_wd[0]),
    .cpu_rd(cpu_rd[0]), .cpu_ready(cpu_ready[0]),
    .ext_req(ext_req[0]), .ext_we(ext_we[0]), .ext_adr(ext_adr[0]), .ext_wd(ext_wd[0]),
    .ext_rd(ext_rd[0]), .ext_ready(ext_ready[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_adr(mem_adr[0]), .mem_wd(mem_wd[0]),
    .mem_rd(mem_rd[0])
  );

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .LATENCY(L1)) u_dut_l3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_adr(cpu_adr[1]), .cpu_wd(cpu_wd[1]),
    .cpu_rd(cpu_rd[1]), .cpu_ready(cpu_ready[1]),
    .ext_req(ext_req[1]), .ext_we(ext_we[1]), .ext_adr(ext_adr[1]), .ext_wd(ext_wd[1]),
    .ext_rd(ext_rd[1]), .ext_ready(ext_ready[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_adr(mem_adr[1]), .mem_wd(mem_wd[1]),
    .mem_rd(mem_rd[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor samples on the falling edge; the driver acts 1 time unit later.
  always @(negedge clk) begin
    txn_t t;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        busy_cnt[d]   = 0;
        exp_cpu_rd[d] = 32'h0;
        exp_ext_rd[d] = 32'h0;
      end
      if (mem_en[d]) begin
        if (sbq.size() == 0 || sbq[0].d != d) begin
          check_eq("unexp_mem_en", 1, 0);
        end else begin
          check_eq("mem_we",  {63'h0, mem_we[d]}, {63'h0, sbq[0].we});
          check_eq("mem_adr", {32'h0, mem_adr[d]}, {32'h0, sbq[0].adr});
          check_eq("mem_wd",  {32'h0, mem_wd[d]},  {32'h0, sbq[0].wd});
          busy_cnt[d]++;
        end
      end else begin
        check_eq("mem_idle", {mem_we[d], mem_adr[d], mem_wd[d]}, 65'h0);
      end
      if (cpu_ready[d] || ext_ready[d]) begin
        if (sbq.size() == 0 || sbq[0].d != d) begin
          check_eq("unexp_ready", 1, 0);
        end else begin
          t = sbq.pop_front();
          if (t.who == 1'b0) exp_cpu_rd[d] = mem_fn(t.adr);
          else               exp_ext_rd[d] = mem_fn(t.adr);
          check_eq("ready_cpu", {63'h0, cpu_ready[d]}, {63'h0, ~t.who});
          check_eq("ready_ext", {63'h0, ext_ready[d]}, {63'h0, t.who});
          check_eq("cpu_rd", {32'h0, cpu_rd[d]}, {32'h0, exp_cpu_rd[d]});
          check_eq("ext_rd", {32'h0, ext_rd[d]}, {32'h0, exp_ext_rd[d]});
          check_eq("busy_len", busy_cnt[d], lat_of(d));
          busy_cnt[d] = 0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int d, input bit who, input bit req, input bit we,
                         input logic [31:0] adr, input logic [31:0] wd);
    if (who == 1'b0) begin
      cpu_req[d] = req; cpu_we[d] = we; cpu_adr[d] = adr; cpu_wd[d] = wd;
    end else begin
      ext_req[d] = req; ext_we[d] = we; ext_adr[d] = adr; ext_wd[d] = wd;
    end
  endtask

  task automatic push(input int d, input bit who, input bit we,
                      input logic [31:0] adr, input logic [31:0] wd);
    txn_t t;
    t.d = d; t.who = who; t.we = we; t.adr = adr; t.wd = wd;
    sbq.push_back(t);
  endtask

  // Returns the number of steps until a ready pulse, or -1 on timeout.
  task automatic wait_ready(input int d, input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (cpu_ready[d] || ext_ready[d]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic txn(input int d, input bit who, input bit we,
                     input logic [31:0] adr, input logic [31:0] wd);
    int n;
    step();
    set_req(d, who, 1'b1, we, adr, wd);
    push(d, who, we, adr, wd);
    wait_ready(d, 30, n);
    check_eq("latency", n, lat_of(d) + 1);
    set_req(d, who, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    sbq.delete();
    mlast = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Both requests held for n grants; expected winners come from the bench model.
  task automatic contend(input int d, input int n);
    int  m;
    bit  who;
    step();
    set_req(d, 1'b0, 1'b1, 1'b0, 32'h100, 32'h11);
    set_req(d, 1'b1, 1'b1, 1'b1, 32'h200, 32'h22);
    for (int k = 0; k < n; k++) begin
      who   = RR ? ~mlast : 1'b0;
      mlast = who;
      if (who == 1'b0) push(d, 1'b0, 1'b0, 32'h100, 32'h11);
      else             push(d, 1'b1, 1'b1, 32'h200, 32'h22);
    end
    for (int k = 0; k < n; k++) begin
      wait_ready(d, 30, m);
      check_eq("contend_lat", m, (k == 0) ? lat_of(d) + 1 : lat_of(d) + 2);
    end
    set_req(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(d, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    mlast = 1'b1;
    for (int d = 0; d < 2; d++) begin
      set_req(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(d, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_outs", {cpu_ready[d], ext_ready[d], mem_en[d], mem_we[d]}, 64'h0);
      check_eq("rst_rd", {cpu_rd[d], ext_rd[d]}, 64'h0);
      check_eq("rst_mem", {mem_adr[d], mem_wd[d]}, 64'h0);
    end
    reset = 1'b0;

    // LATENCY=1: core read of 0x40 returns DEADBEEF two cycles after sampling.
    txn(0, 1'b0, 1'b0, 32'h40, 32'h0);
    check_eq("cpu_rd_l1", {32'h0, cpu_rd[0]}, 64'hDEADBEEF);
    txn(0, 1'b1, 1'b0, 32'h44, 32'h0);
    txn(0, 1'b0, 1'b1, 32'h48, 32'hCAFE0001);

    // LATENCY=3: external write; core read data must be left alone.
    txn(1, 1'b0, 1'b0, 32'h40, 32'h0);
    txn(1, 1'b1, 1'b1, 32'h80, 32'h12345678);
    check_eq("cpu_rd_hold", {32'h0, cpu_rd[1]}, 64'hDEADBEEF);

    // Ties after reset.
    do_reset();
    contend(1, 4);
    do_reset();
    contend(0, 3);

    // External request arriving during a core BUSY phase waits for IDLE.
    step();
    set_req(1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
    push(1, 1'b0, 1'b0, 32'h300, 32'h0);
    step();
    step();
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h304, 32'h0);
    push(1, 1'b1, 1'b0, 32'h304, 32'h0);
    wait_ready(1, 30, n);
    check_eq("late_cpu_lat", n, L1 - 1);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_ready(1, 30, n);
    check_eq("late_ext_lat", n, L1 + 2);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset in the second BUSY cycle aborts; the held request then completes.
    step();
    set_req(1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    push(1, 1'b0, 1'b0, 32'h40, 32'h0);
    step();
    step();
    reset = 1'b1;
    sbq.delete();
    #1;
    check_eq("abort_outs", {cpu_ready[1], ext_ready[1], mem_en[1], mem_we[1]}, 64'h0);
    check_eq("abort_mem", {mem_adr[1], mem_wd[1]}, 64'h0);
    check_eq("abort_rd", {cpu_rd[1], ext_rd[1]}, 64'h0);
    step();
    check_eq("abort_noready", {62'h0, cpu_ready[1], ext_ready[1]}, 64'h0);
    step();
    push(1, 1'b0, 1'b0, 32'h40, 32'h0);
    reset = 1'b0;
    wait_ready(1, 30, n);
    check_eq("post_rst_lat", n, L1 + 1);
    check_eq("post_rst_rd", {32'h0, cpu_rd[1]}, 64'hDEADBEEF);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    repeat (6) step();
    check_eq("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
